// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed scan of a multi-digit active-low seven-segment display.
// One digit per REFRESH_DIV-cycle slot; anode/seg are registered and lag the scan state by 1 cycle.
// Loads are held pending and committed only on the frame wrap; LEADING_ZERO_BLANK_EN blanks leading zeros.

// Hex nibble to active-low segment pattern, seg_o[0]=a .. seg_o[6]=g.
module seven_seg_decoder (
  input  logic [3:0] nibble_i,
  output logic [0:6] seg_o
);

  // Pure lookup; a cleared bit lights the segment.
  always_comb begin
    case (nibble_i)
      4'h0:    seg_o = 7'b0000001;
      4'h1:    seg_o = 7'b1001111;
      4'h2:    seg_o = 7'b0010010;
      4'h3:    seg_o = 7'b0000110;
      4'h4:    seg_o = 7'b1001100;
      4'h5:    seg_o = 7'b0100100;
      4'h6:    seg_o = 7'b0100000;
      4'h7:    seg_o = 7'b0001111;
      4'h8:    seg_o = 7'b0000000;
      4'h9:    seg_o = 7'b0000100;
      4'hA:    seg_o = 7'b0001000;
      4'hB:    seg_o = 7'b1100000;
      4'hC:    seg_o = 7'b0110001;
      4'hD:    seg_o = 7'b1000010;
      4'hE:    seg_o = 7'b0110000;
      default: seg_o = 7'b0111000;
    endcase
  end

endmodule

module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    load_ack,
  output logic                    frame_start,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_sel,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [0:6]              seg
);

  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] GUARD    = PRE_W'(GUARD_CYCLES);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic                    pend_vld_q, pend_vld_d;
  logic                    ack_q, ack_d;
  logic                    fs_q, fs_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [0:6]              seg_q, seg_d;

  logic       tc, wrap;
  logic [3:0] nibble;
  logic       en_bit, digit_on;
  logic [0:6] dec_seg;

  assign tc   = (pre_q == LAST_PRE);
  assign wrap = tc && (sel_q == LAST_SEL);

  // Scan advance plus pending/commit bookkeeping; the display value only changes on a wrap.
  always_comb begin
    pre_d      = tc ? '0 : pre_q + 1'b1;
    sel_d      = sel_q;
    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (tc) begin
      sel_d = (sel_q == LAST_SEL) ? '0 : sel_q + 1'b1;
    end
    if (wrap) begin
      // A load landing on the wrap itself goes straight to the display.
      if (load) begin
        disp_d = value_in;
      end else if (pend_vld_q) begin
        disp_d = pend_q;
      end
      pend_vld_d = 1'b0;
    end else if (load) begin
      pend_d     = value_in;
      pend_vld_d = 1'b1;
    end
    ack_d = wrap & (load | pend_vld_q);
    fs_d  = wrap;
  end

  // Select the current digit's nibble and enable bit.
  always_comb begin
    nibble = 4'h0;
    en_bit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_q == SEL_W'(i)) begin
        nibble = disp_q[4*i +: 4];
        en_bit = digit_en[i];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [SEL_W-1:0] msd;

  // Index of the most significant non-zero nibble; 0 when the value is zero so digit 0 stays lit.
  always_comb begin
    msd = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (disp_q[4*i +: 4] != 4'h0) begin
        msd = SEL_W'(i);
      end
    end
  end

  assign digit_on = en_bit & (sel_q <= msd);
`else
  assign digit_on = en_bit;
`endif

  seven_seg_decoder u_dec (
    .nibble_i (nibble),
    .seg_o    (dec_seg)
  );

  // Next display drive: blank during the guard window or for a dark digit, else one anode low.
  always_comb begin
    anode_d = '1;
    seg_d   = 7'b1111111;
    if ((pre_q >= GUARD) && digit_on) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        anode_d[i] = (sel_q != SEL_W'(i));
      end
      seg_d = dec_seg;
    end
  end

  // State and registered outputs; reset wins over everything, including a pending value.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q      <= '0;
      sel_q      <= '0;
      disp_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ack_q      <= 1'b0;
      fs_q       <= 1'b0;
      anode_q    <= '1;
      seg_q      <= 7'b1111111;
    end else begin
      pre_q      <= pre_d;
      sel_q      <= sel_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ack_q      <= ack_d;
      fs_q       <= fs_d;
      anode_q    <= anode_d;
      seg_q      <= seg_d;
    end
  end

  assign load_ack    = ack_q;
  assign frame_start = fs_q;
  assign digit_sel   = sel_q;
  assign anode       = anode_q;
  assign seg         = seg_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1.
// Every cycle's outputs are predicted from a behavioural model and queued, then compared.
// Table vectors load values and check one whole frame of slot contents against constants.
module tb_seven_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int GC = 1;

  logic        clk = 1'b0;
  logic        reset, load;
  logic [15:0] value_in;
  logic [3:0]  digit_en;
  logic        load_ack, frame_start;
  logic [1:0]  digit_sel;
  logic [3:0]  anode;
  logic [0:6]  seg;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYCLES(GC)) dut (
    .clk         (clk),
    .reset       (reset),
    .value_in    (value_in),
    .load        (load),
    .digit_en    (digit_en),
    .load_ack    (load_ack),
    .frame_start (frame_start),
    .digit_sel   (digit_sel),
    .anode       (anode),
    .seg         (seg)
  );

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] seg;
    logic       ack;
    logic       fs;
    logic [1:0] sel;
  } obs_t;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  en;
    logic [27:0] segs;   // digit d expected at [7*d +: 7]; 7'h7F = digit must stay dark
  } vec_t;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   ack_cnt = 0;

  // Reference model state
  int          m_pre, m_sel;
  logic [15:0] m_disp, m_pend;
  bit          m_pvld;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
          7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
          7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return t[n];
  endfunction

  function automatic bit m_show(input int d);
    int top;
    top = 0;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 0; i < ND; i++) if (m_disp[4*i +: 4] != 4'h0) top = i;
`else
    top = ND - 1;
`endif
    return digit_en[d] && (d <= top);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // One clock: drive at negedge, predict, clock, compare the popped prediction.
  task automatic step(input bit rst, input bit ld, input logic [15:0] v);
    obs_t e, a;
    bit   tc, wrap;
    reset    = rst;
    load     = ld;
    value_in = v;
    tc   = (m_pre == RD - 1);
    wrap = tc && (m_sel == ND - 1);
    e = '0;
    if (rst) begin
      e.anode = 4'hF;
      e.seg   = 7'h7F;
    end else begin
      e.fs  = wrap;
      e.ack = wrap && (ld || m_pvld);
      e.sel = 2'(tc ? (m_sel + 1) % ND : m_sel);
      if (m_pre >= GC && m_show(m_sel)) begin
        e.anode = ~(4'b0001 << m_sel);
        e.seg   = hex_seg(m_disp[4*m_sel +: 4]);
      end else begin
        e.anode = 4'hF;
        e.seg   = 7'h7F;
      end
    end
    exp_q.push_back(e);
    if (rst) begin
      m_pre = 0; m_sel = 0; m_disp = '0; m_pend = '0; m_pvld = 0;
    end else begin
      if (wrap) begin
        if (ld) m_disp = v;
        else if (m_pvld) m_disp = m_pend;
        m_pvld = 0;
      end else if (ld) begin
        m_pend = v;
        m_pvld = 1;
      end
      m_sel = tc ? (m_sel + 1) % ND : m_sel;
      m_pre = tc ? 0 : m_pre + 1;
    end
    @(posedge clk);
    #1;
    a = {anode, seg, load_ack, frame_start, digit_sel};
    e = exp_q.pop_front();
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL cycle anode/seg/ack/fs/sel: got %b/%b/%b/%b/%0d, expected %b/%b/%b/%b/%0d",
               a.anode, a.seg, a.ack, a.fs, a.sel, e.anode, e.seg, e.ack, e.fs, e.sel);
    end
    if ($countones(~anode) > 1) begin
      n_bad++;
      $display("FAIL one_anode: got anode %b, expected at most one low bit", anode);
    end
    if (load_ack === 1'b1) ack_cnt++;
    @(negedge clk);
  endtask

  task automatic wait_fs();
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(0, 0, 16'h0);
      seen = (frame_start === 1'b1);
    end
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_fs: got no frame_start in 40 cycles, expected one");
    end
  endtask

  // Observe the next full frame (called on a frame_start cycle) and check each digit's slot.
  task automatic check_frame(input string name, input logic [27:0] segs);
    int         lit [ND];
    logic [6:0] got [ND];
    for (int d = 0; d < ND; d++) begin lit[d] = 0; got[d] = 7'h7F; end
    for (int c = 0; c < RD * ND; c++) begin
      step(0, 0, 16'h0);
      for (int d = 0; d < ND; d++) begin
        if (anode[d] === 1'b0) begin
          lit[d]++;
          got[d] = seg;
        end
      end
    end
    for (int d = 0; d < ND; d++) begin
      if (segs[7*d +: 7] == 7'h7F)
        chk($sformatf("%s dig%0d lit", name, d), 32'(lit[d]), 32'd0);
      else
        chk($sformatf("%s dig%0d seg/lit", name, d), {got[d], 8'(lit[d])},
            {segs[7*d +: 7], 8'(RD - GC)});
    end
  endtask

  vec_t vecs [6];
  int   first_fs;

  initial begin
    vecs[0] = '{16'h12A0, 4'hF, {7'b1001111, 7'b0010010, 7'b0001000, 7'b0000001}};
    vecs[1] = '{16'h3456, 4'hF, {7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000}};
    vecs[2] = '{16'h12A0, 4'b0101, {7'h7F, 7'b0010010, 7'h7F, 7'b0000001}};
    vecs[3] = '{16'h9C8D, 4'b1010, {7'b0000100, 7'h7F, 7'b0000000, 7'h7F}};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[4] = '{16'h0005, 4'hF, {7'h7F, 7'h7F, 7'h7F, 7'b0100100}};
    vecs[5] = '{16'h0000, 4'hF, {7'h7F, 7'h7F, 7'h7F, 7'b0000001}};
`else
    vecs[4] = '{16'h0005, 4'hF, {7'b0000001, 7'b0000001, 7'b0000001, 7'b0100100}};
    vecs[5] = '{16'h0000, 4'hF, {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}};
`endif

    reset = 1'b1; load = 1'b0; value_in = '0; digit_en = 4'hF;
    m_pre = 0; m_sel = 0; m_disp = '0; m_pend = '0; m_pvld = 0;
    @(negedge clk);

    // Reset held 3 cycles, then time to the first frame_start.
    for (int i = 0; i < 3; i++) step(1, 0, 16'h0);
    chk("reset anode", 32'(anode), 32'hF);
    chk("reset seg", 32'(seg), 32'h7F);
    chk("reset digit_sel", 32'(digit_sel), 32'd0);
    chk("reset load_ack", 32'(load_ack), 32'd0);
    first_fs = 0;
    for (int i = 1; i <= 40 && first_fs == 0; i++) begin
      step(0, 0, 16'h0);
      if (frame_start === 1'b1) first_fs = i;
    end
    chk("first frame_start delay", 32'(first_fs), 32'd16);

    // Table: one load per vector, one ack at the wrap, then a full frame of slot contents.
    for (int v = 0; v < 6; v++) begin
      digit_en = vecs[v].en;
      ack_cnt  = 0;
      step(0, 1, vecs[v].val);
      wait_fs();
      chk($sformatf("vec%0d ack count", v), 32'(ack_cnt), 32'd1);
      check_frame($sformatf("vec%0d", v), vecs[v].segs);
    end
    digit_en = 4'hF;

    // Two loads in one frame: last one wins, single ack, 1111 never shown.
    ack_cnt = 0;
    step(0, 1, 16'h1111);
    step(0, 0, 16'h0);
    step(0, 0, 16'h0);
    step(0, 1, 16'h2222);
    wait_fs();
    chk("double load ack count", 32'(ack_cnt), 32'd1);
    check_frame("double load", {4{7'b0010010}});

    // Load exactly on the wrap cycle bypasses the pending register.
    for (int i = 0; i < 40 && !(m_pre == RD - 1 && m_sel == ND - 1); i++) step(0, 0, 16'h0);
    chk("reach wrap", 32'(m_pre * 16 + m_sel), 32'((RD - 1) * 16 + ND - 1));
    step(0, 1, 16'hBEEF);
    chk("wrap load ack+fs", {30'd0, load_ack, frame_start}, 32'd3);
    check_frame("wrap load", {7'b1100000, 7'b0110000, 7'b0110000, 7'b0111000});

    // Mid-slot reset with a value pending: no ack may follow.
    step(0, 1, 16'h4321);
    step(0, 0, 16'h0);
    step(1, 0, 16'h0);
    chk("midreset outputs", {anode, 1'b0, seg, 2'b0, load_ack, frame_start, digit_sel},
        {4'hF, 1'b0, 7'h7F, 2'b0, 1'b0, 1'b0, 2'd0});
    ack_cnt = 0;
    for (int i = 0; i < 40; i++) step(0, 0, 16'h0);
    chk("midreset ack count", 32'(ack_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
